pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter POR_CYCLES, default 1024, number of clk cycles pll_reset is held high per PLL reset pulse.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 4096, number of consecutive synchronized-lock-high cycles required before reset release.
REQ-003 Parameter STAGE_GAP, default 256, clk cycles between successive reset releases.
REQ-004 Parameter LOCK_TIMEOUT_CYCLES, default 270000 (10 ms at 27 MHz), maximum wait for lock after a PLL reset pulse.
REQ-005 Ports, in order: clk in 1, free-running 27 MHz board oscillator, the same clock that feeds the PLL input; reset_n in 1, asynchronous active-low reset.
REQ-006 pll_lock in 1, PLL lock flag, asynchronous to clk; pll_reset out 1, active-high PLL reset.
REQ-007 sys_rst_n out 1, pixel/system-domain reset, active low; cam_rst_n out 1, camera sensor reset, active low.
REQ-008 cfg_start out 1, single-cycle pulse that starts sensor register configuration; ready out 1, level, high while in RUN.
REQ-009 relock_count out 8, saturating count of lock losses and timeouts since reset_n.

Function
REQ-010 pll_lock is synchronized by a two-flop synchronizer (lock_s) before any use; lock_s lags pll_lock by 2 clk cycles.
REQ-011 A single 20-bit down counter times all states; every parameter is in the range 1..2^20-1.
REQ-012 The FSM has states PLL_RST, WAIT_LOCK, STABLE, REL_SYS, REL_CAM and RUN.
REQ-013 PLL_RST: pll_reset=1 for exactly POR_CYCLES cycles, then go to WAIT_LOCK; pll_reset=0 in all other states.
REQ-014 WAIT_LOCK: if lock_s=1, go to STABLE; otherwise, when the timeout (REQ-032) expires, go to PLL_RST and increment relock_count.
REQ-015 STABLE: counts consecutive lock_s=1 cycles; after LOCK_STABLE_CYCLES of them, go to REL_SYS; if lock_s=0, go to WAIT_LOCK with the counter reloaded and relock_count unchanged.
REQ-016 REL_SYS: sys_rst_n=1 on the first cycle of the state; after STAGE_GAP cycles, go to REL_CAM.
REQ-017 REL_CAM: cam_rst_n=1 on the first cycle of the state; after STAGE_GAP cycles, go to RUN.
REQ-018 RUN: cfg_start=1 for exactly the first cycle in RUN; ready=1 for the whole state; the FSM stays in RUN while lock_s=1.
REQ-019 lock_s=0 in REL_SYS, REL_CAM or RUN: next cycle sys_rst_n=0, cam_rst_n=0, ready=0, cfg_start=0, state PLL_RST, relock_count incremented.
REQ-020 relock_count saturates at 255 and does not wrap.
REQ-021 Release ordering is fixed: sys_rst_n rises strictly before cam_rst_n, which rises strictly before cfg_start.
REQ-022 sys_rst_n and cam_rst_n are low in PLL_RST, WAIT_LOCK and STABLE.
REQ-023 All outputs are registered.
REQ-024 A lock glitch shorter than 1 clk cycle need not be seen; a low lasting 2 or more clk cycles is always seen.
REQ-025 cfg_start is emitted exactly once per RUN entry, never re-asserts while in RUN, and re-asserts only after a full re-sequence.

Reset
REQ-026 reset_n low asynchronously forces: state PLL_RST with counter loaded to POR_CYCLES; pll_reset=1; sys_rst_n=0; cam_rst_n=0; cfg_start=0; ready=0; relock_count=0; synchronizer flops=0.
REQ-027 reset_n low mid-sequence (any state) aborts the sequence; no partial release persists.
REQ-028 Deassertion of reset_n is used as-is (the board supplies a synchronized release); the first active cycle begins the PLL_RST count.

Configuration
REQ-029 The macro PLL_LOCK_TIMEOUT_EN selects the WAIT_LOCK timeout behaviour.
REQ-030 With PLL_LOCK_TIMEOUT_EN defined, the timeout of REQ-032 applies.
REQ-031 Without PLL_LOCK_TIMEOUT_EN, WAIT_LOCK waits indefinitely for lock_s, and relock_count counts lock losses only.
REQ-032 The WAIT_LOCK timeout expires after LOCK_TIMEOUT_CYCLES cycles without lock_s, re-pulses the PLL reset and increments relock_count.

Verification
REQ-033 All directed scenarios use POR_CYCLES=4, LOCK_STABLE_CYCLES=8, STAGE_GAP=3, LOCK_TIMEOUT_CYCLES=50.
REQ-034 Nominal: pll_lock rises 10 cycles after reset_n release and stays high -> pll_reset high exactly 4 cycles; sys_rst_n rises 2+8 cycles after lock; cam_rst_n rises 3 cycles after sys_rst_n; cfg_start is one pulse 3 cycles after cam_rst_n; ready=1; relock_count=0.
REQ-035 Lock chatter: pll_lock high 5 cycles, low 3 cycles, then high -> no reset release until 8 consecutive lock_s cycles; relock_count stays 0.
REQ-036 Timeout (macro defined): pll_lock held low -> pll_reset re-pulses every 4+50 cycles and relock_count increments each time; without the macro, a single pll_reset pulse only and relock_count=0.
REQ-037 Lock loss in RUN: pll_lock low for 3 cycles -> all resets reasserted, ready=0, relock_count=1, and a full re-sequence with a second cfg_start pulse.
REQ-038 Saturation and reset: force 300 lock losses -> relock_count=255; reset_n pulsed low during REL_CAM -> all outputs at reset values immediately (asynchronously), and relock_count=0.

Source files
------------

// File: rtl/pll_reset_seq.sv
`timescale 1ns/1ps
// pll_reset_seq
// Brings up the board PLL and then releases the downstream resets in a fixed
// order: PLL reset pulse, wait for lock, require a run of stable lock, release
// the system domain, release the camera sensor, then pulse cfg_start once and
// hold ready. Any loss of lock after release restarts the whole sequence.
//
// Build option: define PLL_LOCK_TIMEOUT_EN to make WAIT_LOCK give up after
// LOCK_TIMEOUT_CYCLES without lock, re-pulse the PLL reset and count it in
// relock_count. Without it WAIT_LOCK waits indefinitely.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// PLL_RST   | pll_reset held high for POR_CYCLES
// WAIT_LOCK | waiting for synchronized lock (optional timeout)
// STABLE    | lock must stay high for LOCK_STABLE_CYCLES consecutive cycles
// REL_SYS   | sys_rst_n released, waiting STAGE_GAP before the camera
// REL_CAM   | cam_rst_n released, waiting STAGE_GAP before RUN
// RUN       | fully up: cfg_start on entry, ready high, lock watched

module pll_reset_seq #(
    parameter int unsigned POR_CYCLES          = 1024,
    parameter int unsigned LOCK_STABLE_CYCLES  = 4096,
    parameter int unsigned STAGE_GAP           = 256,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       cam_rst_n,
    output logic       cfg_start,
    output logic       ready,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_SYS   = 3'd3,
        REL_CAM   = 3'd4,
        RUN       = 3'd5
    } state_t;

    // Counter reload values. The WAIT_LOCK cycle that first sees lock counts
    // as the first sample of the stable run, so STABLE needs one fewer.
    localparam logic [19:0] POR_LD     = 20'(POR_CYCLES);
    localparam logic [19:0] STABLE_LD  = 20'(LOCK_STABLE_CYCLES - 1);
    localparam logic [19:0] GAP_LD     = 20'(STAGE_GAP);
    localparam logic [19:0] TIMEOUT_LD = 20'(LOCK_TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  relock_count_q, relock_count_d;
    logic        relock_inc;

    logic        lock_meta_q, lock_meta_d;
    logic        lock_s_q, lock_s_d;

    logic        pll_reset_q, pll_reset_d;
    logic        sys_rst_n_q, sys_rst_n_d;
    logic        cam_rst_n_q, cam_rst_n_d;
    logic        cfg_start_q, cfg_start_d;
    logic        ready_q, ready_d;

    // Two-flop synchronizer input stage for the asynchronous lock flag.
    always_comb begin
        lock_meta_d = pll_lock;
        lock_s_d    = lock_meta_q;
    end

    // Synchronizer flops; cleared by reset so lock is never assumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
        end
    end

    // Next-state, shared down-counter and relock bookkeeping.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        relock_inc = 1'b0;

        case (state_q)
            PLL_RST: begin
                if (cnt_q <= 20'd1) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LD;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end

            WAIT_LOCK: begin
                if (lock_s_q) begin
                    if (LOCK_STABLE_CYCLES == 1) begin
                        state_d = REL_SYS;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = STABLE;
                        cnt_d   = STABLE_LD;
                    end
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                else if (cnt_q <= 20'd1) begin
                    state_d    = PLL_RST;
                    cnt_d      = POR_LD;
                    relock_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
`endif
            end

            STABLE: begin
                // A dropout here is not a lock loss: just start waiting again.
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TIMEOUT_LD;
                end else if (cnt_q <= 20'd1) begin
                    state_d = REL_SYS;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end

            REL_SYS: begin
                if (!lock_s_q) begin
                    state_d    = PLL_RST;
                    cnt_d      = POR_LD;
                    relock_inc = 1'b1;
                end else if (cnt_q <= 20'd1) begin
                    state_d = REL_CAM;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end

            REL_CAM: begin
                if (!lock_s_q) begin
                    state_d    = PLL_RST;
                    cnt_d      = POR_LD;
                    relock_inc = 1'b1;
                end else if (cnt_q <= 20'd1) begin
                    state_d = RUN;
                    cnt_d   = POR_LD;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end

            RUN: begin
                if (!lock_s_q) begin
                    state_d    = PLL_RST;
                    cnt_d      = POR_LD;
                    relock_inc = 1'b1;
                end
            end

            default: begin
                state_d = PLL_RST;
                cnt_d   = POR_LD;
            end
        endcase

        relock_count_d = relock_count_q;
        if (relock_inc && (relock_count_q != 8'hFF)) begin
            relock_count_d = relock_count_q + 8'd1;
        end
    end

    // Output decode from the next state so every output leaves a flop and
    // lines up with the state register.
    always_comb begin
        pll_reset_d = (state_d == PLL_RST);
        sys_rst_n_d = (state_d == REL_SYS) || (state_d == REL_CAM) || (state_d == RUN);
        cam_rst_n_d = (state_d == REL_CAM) || (state_d == RUN);
        ready_d     = (state_d == RUN);
        cfg_start_d = (state_d == RUN) && (state_q != RUN);
    end

    // State, counter and relock counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= PLL_RST;
            cnt_q          <= POR_LD;
            relock_count_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            relock_count_q <= relock_count_d;
        end
    end

    // Registered outputs; reset holds the PLL in reset and everything else off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            cam_rst_n_q <= 1'b0;
            cfg_start_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            cam_rst_n_q <= cam_rst_n_d;
            cfg_start_q <= cfg_start_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_reset    = pll_reset_q;
    assign sys_rst_n    = sys_rst_n_q;
    assign cam_rst_n    = cam_rst_n_q;
    assign cfg_start    = cfg_start_q;
    assign ready        = ready_q;
    assign relock_count = relock_count_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
`timescale 1ns/1ps
// Bench for pll_reset_seq with short timing parameters. Expected event cycles
// are pushed to a scoreboard when stimulus is applied and popped when the
// corresponding output edge is observed.

module tb_pll_reset_seq;

    localparam int POR  = 4;
    localparam int STAB = 8;
    localparam int GAP  = 3;
    localparam int TMO  = 50;

    localparam int SIG_PLL = 0;
    localparam int SIG_SYS = 1;
    localparam int SIG_CAM = 2;
    localparam int SIG_CFG = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       cam_rst_n;
    logic       cfg_start;
    logic       ready;
    logic [7:0] relock_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cfg_cycles = 0;
    int exp_relock = 0;

    string sb_name[$];
    int    sb_exp[$];

    pll_reset_seq #(
        .POR_CYCLES          (POR),
        .LOCK_STABLE_CYCLES  (STAB),
        .STAGE_GAP           (GAP),
        .LOCK_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .sys_rst_n    (sys_rst_n),
        .cam_rst_n    (cam_rst_n),
        .cfg_start    (cfg_start),
        .ready        (ready),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) cfg_cycles <= cfg_cycles + ((cfg_start === 1'b1) ? 1 : 0);

    function automatic logic sig_of(input int which);
        case (which)
            SIG_PLL: return pll_reset;
            SIG_SYS: return sys_rst_n;
            SIG_CAM: return cam_rst_n;
            SIG_CFG: return cfg_start;
            default: return 1'bx;
        endcase
    endfunction

    // Waits (sampling on falling edges) for a signal to reach a level;
    // 'at' is the index of the rising clock edge that produced it.
    task automatic wait_lvl(input int which, input logic lvl, input int budget,
                            output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig_of(which) === lvl) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic push_exp(input string nm, input int ex);
        sb_name.push_back(nm);
        sb_exp.push_back(ex);
    endtask

    task automatic pop_exp(output string nm, output int ex);
        if (sb_exp.size() == 0) begin
            nm = "empty_scoreboard";
            ex = -2;
        end else begin
            nm = sb_name.pop_front();
            ex = sb_exp.pop_front();
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic do_reset(output int r);
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        exp_relock = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        r = cyc;
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        pll_lock = 1'b0;
        #2;
        reset_n = 1'b0;
        exp_relock = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({pll_reset, sys_rst_n, cam_rst_n, cfg_start, ready} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_outputs: got pll/sys/cam/cfg/ready=%b, expected 10000",
                     {pll_reset, sys_rst_n, cam_rst_n, cfg_start, ready});
        end
        tests++;
        if (relock_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_relock: got %0d, expected 0", relock_count);
        end
    endtask

    task automatic test_nominal();
        int r, k, at, ex, cfg0;
        bit ok;
        string nm;
        cfg0 = cfg_cycles;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        r = cyc;
        push_exp("nom_pll_reset_fall", r + POR);
        wait_lvl(SIG_PLL, 1'b0, 40, ok, at);
        pop_exp(nm, ex);
        tests++;
        if (!ok || at !== ex) begin
            fails++;
            $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
        end
        do begin
            @(posedge clk);
            #1;
        end while (cyc < r + 10);
        pll_lock = 1'b1;
        k = cyc;
        push_exp("nom_sys_rise", k + 2 + STAB);
        push_exp("nom_cam_rise", k + 2 + STAB + GAP);
        push_exp("nom_cfg_pulse", k + 2 + STAB + 2 * GAP);
        for (int s = SIG_SYS; s <= SIG_CFG; s++) begin
            wait_lvl(s, 1'b1, 40, ok, at);
            pop_exp(nm, ex);
            tests++;
            if (!ok || at !== ex) begin
                fails++;
                $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
            end
        end
        tests++;
        if (ready !== 1'b1 || int'(relock_count) !== exp_relock) begin
            fails++;
            $display("FAIL nom_run_state: got ready=%b relock=%0d, expected ready=1 relock=%0d",
                     ready, relock_count, exp_relock);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (cfg_cycles - cfg0 !== 1) begin
            fails++;
            $display("FAIL nom_cfg_once: got %0d cfg_start cycles, expected 1", cfg_cycles - cfg0);
        end
        tests++;
        if (ready !== 1'b1 || cfg_start !== 1'b0) begin
            fails++;
            $display("FAIL nom_run_hold: got ready=%b cfg_start=%b, expected ready=1 cfg_start=0",
                     ready, cfg_start);
        end
    endtask

    task automatic test_lock_loss_run();
        int m, at, ex, cfg0, rel;
        bit ok;
        string nm;
        cfg0 = cfg_cycles;
        @(posedge clk);
        #1;
        pll_lock = 1'b0;
        m = cyc;
        exp_relock = sat_inc(exp_relock);
        // detection 3 edges after the drop, then a full PLL reset pulse; lock is
        // already back, so the first WAIT_LOCK sample starts the stable run
        rel = m + 3 + POR + STAB;
        push_exp("loss_sys_fall", m + 3);
        push_exp("loss_pll_reset_fall", m + 3 + POR);
        push_exp("loss_sys_rise", rel);
        push_exp("loss_cam_rise", rel + GAP);
        push_exp("loss_cfg_pulse", rel + 2 * GAP);
        repeat (3) @(posedge clk);
        #1;
        pll_lock = 1'b1;
        wait_lvl(SIG_SYS, 1'b0, 10, ok, at);
        pop_exp(nm, ex);
        tests++;
        if (!ok || at !== ex) begin
            fails++;
            $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
        end
        tests++;
        if ({pll_reset, cam_rst_n, cfg_start, ready} !== 4'b1000) begin
            fails++;
            $display("FAIL loss_outputs: got pll/cam/cfg/ready=%b, expected 1000",
                     {pll_reset, cam_rst_n, cfg_start, ready});
        end
        tests++;
        if (int'(relock_count) !== exp_relock) begin
            fails++;
            $display("FAIL loss_relock: got %0d, expected %0d", relock_count, exp_relock);
        end
        wait_lvl(SIG_PLL, 1'b0, 20, ok, at);
        pop_exp(nm, ex);
        tests++;
        if (!ok || at !== ex) begin
            fails++;
            $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
        end
        for (int s = SIG_SYS; s <= SIG_CFG; s++) begin
            wait_lvl(s, 1'b1, 40, ok, at);
            pop_exp(nm, ex);
            tests++;
            if (!ok || at !== ex) begin
                fails++;
                $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
            end
        end
        repeat (5) @(negedge clk);
        tests++;
        if (cfg_cycles - cfg0 !== 1 || ready !== 1'b1) begin
            fails++;
            $display("FAIL loss_resequence: got cfg cycles=%0d ready=%b, expected 1 and 1",
                     cfg_cycles - cfg0, ready);
        end
    endtask

    task automatic test_saturation_reset();
        int at, ex;
        bit ok;
        string nm;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            pll_lock = 1'b0;
            exp_relock = sat_inc(exp_relock);
            push_exp("sat_relock", exp_relock);
            repeat (3) @(posedge clk);
            #1;
            pll_lock = 1'b1;
            wait_lvl(SIG_SYS, 1'b1, 60, ok, at);
            pop_exp(nm, ex);
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL sat_resequence: no sys_rst_n release within 60 cycles, loss %0d", i);
                break;
            end
            if (i == 0 || i == 252 || i == 253 || i == 254 || i == 299) begin
                tests++;
                if (int'(relock_count) !== ex) begin
                    fails++;
                    $display("FAIL %s: got %0d, expected %0d (loss %0d)", nm, relock_count, ex, i);
                end
            end
        end
        wait_lvl(SIG_CAM, 1'b1, 10, ok, at);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_reach_rel_cam: cam_rst_n not released, observed %b, expected 1", cam_rst_n);
        end
        #1;
        reset_n = 1'b0;
        exp_relock = 0;
        #1;
        tests++;
        if ({pll_reset, sys_rst_n, cam_rst_n, cfg_start, ready} !== 5'b10000) begin
            fails++;
            $display("FAIL async_reset_outputs: got pll/sys/cam/cfg/ready=%b, expected 10000",
                     {pll_reset, sys_rst_n, cam_rst_n, cfg_start, ready});
        end
        tests++;
        if (int'(relock_count) !== exp_relock) begin
            fails++;
            $display("FAIL async_reset_relock: got %0d, expected %0d", relock_count, exp_relock);
        end
    endtask

    task automatic test_chatter();
        int r, k, at, ex;
        bit ok;
        string nm;
        do_reset(r);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < r + 10);
        pll_lock = 1'b1;
        k = cyc;
        repeat (5) @(posedge clk);
        #1;
        pll_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pll_lock = 1'b1;
        push_exp("chatter_sys_rise", k + 8 + 2 + STAB);
        wait_lvl(SIG_SYS, 1'b1, 60, ok, at);
        pop_exp(nm, ex);
        tests++;
        if (!ok || at !== ex) begin
            fails++;
            $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
        end
        tests++;
        if (int'(relock_count) !== exp_relock) begin
            fails++;
            $display("FAIL chatter_relock: got %0d, expected %0d", relock_count, exp_relock);
        end
    endtask

    task automatic test_timeout();
        int r, at, ex;
        bit ok;
        string nm;
        do_reset(r);
`ifdef PLL_LOCK_TIMEOUT_EN
        for (int j = 1; j <= 3; j++) begin
            push_exp("timeout_pll_reset_rise", r + j * (POR + TMO));
        end
        for (int j = 1; j <= 3; j++) begin
            wait_lvl(SIG_PLL, 1'b0, 20, ok, at);
            wait_lvl(SIG_PLL, 1'b1, 100, ok, at);
            exp_relock = sat_inc(exp_relock);
            pop_exp(nm, ex);
            tests++;
            if (!ok || at !== ex) begin
                fails++;
                $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
            end
            tests++;
            if (int'(relock_count) !== exp_relock) begin
                fails++;
                $display("FAIL timeout_relock: got %0d, expected %0d", relock_count, exp_relock);
            end
        end
`else
        push_exp("no_timeout_pll_reset_fall", r + POR);
        wait_lvl(SIG_PLL, 1'b0, 20, ok, at);
        pop_exp(nm, ex);
        tests++;
        if (!ok || at !== ex) begin
            fails++;
            $display("FAIL %s: observed cycle %0d, expected %0d", nm, at, ex);
        end
        wait_lvl(SIG_PLL, 1'b1, 200, ok, at);
        tests++;
        if (ok) begin
            fails++;
            $display("FAIL no_timeout_repulse: pll_reset rose at cycle %0d, expected no rise", at);
        end
        tests++;
        if (int'(relock_count) !== exp_relock) begin
            fails++;
            $display("FAIL no_timeout_relock: got %0d, expected %0d", relock_count, exp_relock);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss_run();
        test_saturation_reset();
        test_chatter();
        test_timeout();
        tests++;
        if (sb_exp.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
